// File: rtl/spi_pkg.sv
// Shared types for the SPI arbiter: FSM states and the per-requester master configuration word.
package spi_pkg;

  localparam int SPI_CFG_W = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_DRAIN,
    ST_RELEASE
  } spi_state_t;

  typedef struct packed {
    logic [15:0] clk_div;
    logic        cpol;
    logic        cpha;
    logic        lsb_first;
  } spi_cfg_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Arbiter <-> SPI master link: per-transaction config, TX FIFO push, RX FIFO pop (FWFT), byte-done pulse.
// The arbiter side uses the master modport; the SPI master side (or a model of it) uses slave.
interface spi_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [15:0]           m_clk_div;
  logic                  m_cpol;
  logic                  m_cpha;
  logic                  m_lsb_first;
  logic                  m_wr_en;
  logic [DATA_WIDTH-1:0] m_wr_data;
  logic                  m_full;
  logic                  m_empty;
  logic                  m_rd_en;
  logic [DATA_WIDTH-1:0] m_rd_data;
  logic                  m_done;

  modport master (
    output m_clk_div, m_cpol, m_cpha, m_lsb_first, m_wr_en, m_wr_data, m_rd_en,
    input  m_full, m_empty, m_rd_data, m_done
  );

  modport slave (
    input  m_clk_div, m_cpol, m_cpha, m_lsb_first, m_wr_en, m_wr_data, m_rd_en,
    output m_full, m_empty, m_rd_data, m_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index strictly after ptr, wrapping upward.
// Zero latency; no backpressure, the caller decides when to act on the pick.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    // Offset N lands back on ptr itself, so the previous winner is searched last.
    for (int off = 1; off <= N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among N_REQ requesters, one whole transaction at a time, round-robin.
// Grant 1 cycle after eligible req; pushes 1 byte/cycle while !m_full; rx_valid 2 cycles after m_done.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*LEN_W-1:0]      req_len,
  input  logic [N_REQ*SPI_CFG_W-1:0]  req_cfg,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_tx_data,
  output logic [N_REQ-1:0]            gnt,
  output logic                        tx_pop,
  output logic                        rx_valid,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        xfer_done,
  output logic                        busy,
  spi_arbiter_if.master               mif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  spi_state_t       state, state_nxt;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] tx_cnt;
  logic [LEN_W-1:0] rx_cnt;
  spi_cfg_t         cfg;
  logic             push;
  logic             rd_live;

  for (genvar g = 0; g < N_REQ; g++) begin : g_elig
    assign elig[g] = req[g] && (req_len[g*LEN_W +: LEN_W] != '0);
  end

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req (elig),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any && mif.m_empty) state_nxt = ST_SETUP;
      end
      ST_SETUP: state_nxt = ST_XFER;
      ST_XFER: begin
        push = !mif.m_full && (tx_cnt < len);
        if (push && ((tx_cnt + ONE) == len)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((rx_cnt == len) && !mif.m_rd_en) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign tx_pop          = push;
  assign mif.m_wr_en     = push;
  assign mif.m_wr_data   = push ? req_tx_data[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign mif.m_clk_div   = cfg.clk_div;
  assign mif.m_cpol      = cfg.cpol;
  assign mif.m_cpha      = cfg.cpha;
  assign mif.m_lsb_first = cfg.lsb_first;
  assign xfer_done       = (state == ST_RELEASE);
  assign busy            = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      idx         <= '0;
      ptr         <= IW'(N_REQ - 1);
      len         <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      cfg         <= '0;
      mif.m_rd_en <= 1'b0;
      rd_live     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
    end else begin
      state       <= state_nxt;
      // Every m_done is popped; only those inside a transaction reach the requester.
      mif.m_rd_en <= mif.m_done;
      rd_live     <= mif.m_done && ((state == ST_XFER) || (state == ST_DRAIN));
      rx_valid    <= mif.m_rd_en && rd_live;
      if (mif.m_rd_en && rd_live) begin
        rx_data <= mif.m_rd_data;
        rx_cnt  <= rx_cnt + ONE;
      end
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_SETUP) begin
            gnt <= arb_gnt;
            idx <= arb_idx;
            len <= req_len[arb_idx*LEN_W +: LEN_W];
            cfg <= spi_cfg_t'(req_cfg[arb_idx*SPI_CFG_W +: SPI_CFG_W]);
          end
        end
        ST_SETUP: begin
          tx_cnt <= '0;
          rx_cnt <= '0;
        end
        ST_XFER: begin
          if (push) tx_cnt <= tx_cnt + ONE;
        end
        ST_RELEASE: begin
          gnt <= '0;
          ptr <= idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter; the bench plays the SPI master side cycle by cycle.
module tb_spi_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [75:0] req_cfg;
  logic [31:0] req_tx_data;
  logic [3:0]  gnt;
  logic        tx_pop;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        xfer_done;
  logic        busy;

  logic [3:0]  len_a [4];
  logic [18:0] cfg_a [4];
  logic [7:0]  dat_a [4];
  logic [18:0] m_cfg;

  int n_cmp;
  int n_bad;

  spi_arbiter_if #(.DATA_WIDTH(8)) mif ();

  spi_arbiter #(
    .N_REQ      (4),
    .DATA_WIDTH (8),
    .LEN_W      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_len     (req_len),
    .req_cfg     (req_cfg),
    .req_tx_data (req_tx_data),
    .gnt         (gnt),
    .tx_pop      (tx_pop),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .xfer_done   (xfer_done),
    .busy        (busy),
    .mif         (mif)
  );

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_len[g*4 +: 4]      = len_a[g];
    assign req_cfg[g*19 +: 19]    = cfg_a[g];
    assign req_tx_data[g*8 +: 8]  = dat_a[g];
  end
  assign m_cfg = {mif.m_clk_div, mif.m_cpol, mif.m_cpha, mif.m_lsb_first};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] txb(input int k, input int b);
    if (k == 0 && b == 0) return 8'hA5;
    if (k == 0 && b == 1) return 8'h3C;
    if (k == 0 && b == 2) return 8'hFF;
    return 8'((k << 4) | b);
  endfunction

  function automatic logic [7:0] sb(input int k, input int b);
    return ~txb(k, b);
  endfunction

  // Entered in an IDLE cycle where requester k is already eligible.
  task automatic run_xfer(input int k, input int n, input logic [18:0] cfg,
                          input int fa, input int fl, input int drop);
    int b;
    int c;
    tick; settle;
    chk("setup_gnt", 32'(gnt), 32'(1 << k));
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_cfg", 32'(m_cfg), 32'(cfg));
    chk("setup_wr", 32'(mif.m_wr_en), 32'd0);
    len_a[k] = ~len_a[k];
    cfg_a[k] = ~cfg_a[k];
    b = 0;
    c = 0;
    while (b < n) begin
      tick;
      mif.m_full = (c >= fa) && (c < fa + fl);
      dat_a[k]   = txb(k, b);
      settle;
      if (mif.m_full) begin
        chk("stall_wr", 32'(mif.m_wr_en), 32'd0);
        chk("stall_pop", 32'(tx_pop), 32'd0);
      end else begin
        chk("push_wr", 32'(mif.m_wr_en), 32'd1);
        chk("push_pop", 32'(tx_pop), 32'd1);
        chk("push_dat", 32'(mif.m_wr_data), 32'(txb(k, b)));
        b++;
        if (b == drop) req[k] = 1'b0;
      end
      c++;
    end
    mif.m_full = 1'b0;
    tick; settle;
    chk("drain_wr", 32'(mif.m_wr_en), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      mif.m_done = 1'b1;
      tick;
      mif.m_done    = 1'b0;
      mif.m_rd_data = sb(k, i);
      settle;
      chk("rd_en", 32'(mif.m_rd_en), 32'd1);
      chk("rxv_early", 32'(rx_valid), 32'd0);
      tick; settle;
      chk("rxv", 32'(rx_valid), 32'd1);
      chk("rxd", 32'(rx_data), 32'(sb(k, i)));
    end
    tick; settle;
    chk("rel_done", 32'(xfer_done), 32'd1);
    chk("rel_gnt", 32'(gnt), 32'(1 << k));
    chk("rel_cfg", 32'(m_cfg), 32'(cfg));
    len_a[k] = 4'(n);
    cfg_a[k] = cfg;
    tick; settle;
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_done", 32'(xfer_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) begin
      len_a[i] = '0;
      cfg_a[i] = '0;
      dat_a[i] = '0;
    end
    mif.m_full    = 1'b0;
    mif.m_empty   = 1'b1;
    mif.m_rd_data = '0;
    mif.m_done    = 1'b0;

    tick; tick; settle;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(mif.m_wr_en), 32'd0);
    chk("rst_rd", 32'(mif.m_rd_en), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_done", 32'(xfer_done), 32'd0);
    chk("rst_cfg", 32'(m_cfg), 32'd0);

    // Single requester, three bytes, msb-first mode 0 at divider 4.
    rst      = 1'b0;
    len_a[0] = 4'd3;
    cfg_a[0] = {16'd4, 3'b000};
    req      = 4'b0001;
    run_xfer(0, 3, {16'd4, 3'b000}, 0, 0, 0);

    // Round robin from reset: 0,1,2,3,0, each with its own config.
    req = '0;
    rst = 1'b1;
    tick; tick;
    rst      = 1'b0;
    cfg_a[0] = {16'd2, 3'b000};
    cfg_a[1] = {16'd4, 3'b010};
    cfg_a[2] = {16'd8, 3'b100};
    cfg_a[3] = {16'd16, 3'b001};
    for (int i = 0; i < 4; i++) len_a[i] = 4'd1;
    req = 4'b1111;
    run_xfer(0, 1, {16'd2, 3'b000}, 0, 0, 0);
    run_xfer(1, 1, {16'd4, 3'b010}, 0, 0, 0);
    run_xfer(2, 1, {16'd8, 3'b100}, 0, 0, 0);
    run_xfer(3, 1, {16'd16, 3'b001}, 0, 0, 0);
    run_xfer(0, 1, {16'd2, 3'b000}, 0, 0, 0);

    // Zero length is skipped; req[2] drops after its first byte.
    req      = 4'b0110;
    len_a[1] = 4'd0;
    len_a[2] = 4'd4;
    run_xfer(2, 4, {16'd8, 3'b100}, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick; settle;
      chk("zero_gnt", 32'(gnt), 32'd0);
      chk("zero_busy", 32'(busy), 32'd0);
    end

    // Master FIFO not empty holds off the grant; then a 15-byte burst with 5 full cycles.
    req         = 4'b1000;
    len_a[3]    = 4'd15;
    mif.m_empty = 1'b0;
    tick; settle;
    chk("empty_gnt", 32'(gnt), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    mif.m_empty = 1'b1;
    run_xfer(3, 15, {16'd16, 3'b001}, 4, 5, 0);

    // Reset in the middle of an 8-byte transfer.
    req      = 4'b0001;
    len_a[0] = 4'd8;
    dat_a[0] = txb(0, 0);
    tick; settle;
    chk("r8_gnt", 32'(gnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      dat_a[0] = txb(0, i);
      settle;
      chk("r8_push", 32'(mif.m_wr_en), 32'd1);
    end
    rst = 1'b1;
    tick;
    rst      = 1'b0;
    len_a[0] = 4'd2;
    settle;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr", 32'(mif.m_wr_en), 32'd0);
    chk("mid_rst_pop", 32'(tx_pop), 32'd0);
    run_xfer(0, 2, {16'd2, 3'b000}, 0, 0, 0);

    // Stray m_done while idle: popped, never delivered.
    req = '0;
    tick;
    mif.m_done = 1'b1;
    settle;
    chk("stray_busy0", 32'(busy), 32'd0);
    tick;
    mif.m_done    = 1'b0;
    mif.m_rd_data = 8'h99;
    settle;
    chk("stray_rd", 32'(mif.m_rd_en), 32'd1);
    chk("stray_rxv1", 32'(rx_valid), 32'd0);
    chk("stray_busy1", 32'(busy), 32'd0);
    tick; settle;
    chk("stray_rxv2", 32'(rx_valid), 32'd0);
    chk("stray_rd2", 32'(mif.m_rd_en), 32'd0);
    chk("stray_busy2", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
